// File: rtl/cpu_sequencer.sv
// Multi-cycle control sequencer for the picoMIPS datapath: FETCH/DECODE/EXEC/WB stepping,
// SW[8] wait handshake with optional timeout, single-step pause and halt.
module cpu_sequencer #(
   parameter int unsigned CW       = 16,
   parameter int unsigned WAIT_MAX = 0
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          run,
   input  logic          sw_ready,
   input  logic          step_mode,
   input  logic          step,
   input  logic          dec_w,
   input  logic          dec_pcrel,
   input  logic          dec_wait,
   input  logic          dec_halt,
   output logic          ir_load,
   output logic          pc_en,
   output logic          pc_branch,
   output logic          reg_we,
   output logic [2:0]    state,
   output logic          halted,
   output logic          timeout,
   output logic [CW-1:0] icount
);

   typedef enum logic [2:0] {
      StIdle   = 3'd0,
      StFetch  = 3'd1,
      StDecode = 3'd2,
      StExec   = 3'd3,
      StWaitSw = 3'd4,
      StWb     = 3'd5,
      StPause  = 3'd6,
      StHalt   = 3'd7
   } state_e;

   localparam bit          HasTimeout = (WAIT_MAX != 0);
   localparam logic [31:0] WaitLast   = HasTimeout ? 32'(WAIT_MAX - 1) : 32'd0;

   state_e      state_q, state_d;
   logic [2:0]  sw_sync_q;    // [0],[1] synchroniser, [2] edge-detect delay
   logic [2:0]  step_sync_q;
   logic [31:0] wait_cnt_q;
   logic        sw_edge, step_edge, wait_expired;

   assign sw_edge      = sw_sync_q[1] & ~sw_sync_q[2];
   assign step_edge    = step_sync_q[1] & ~step_sync_q[2];
   assign wait_expired = HasTimeout && (wait_cnt_q == WaitLast);
   assign state        = state_q;

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:   if (run) state_d = StFetch;
         StFetch:  state_d = StDecode;
         StDecode: state_d = dec_halt ? StHalt : StExec;
         StExec:   state_d = dec_wait ? StWaitSw : StWb;
         StWaitSw: if (sw_edge || wait_expired) state_d = StWb;
         StWb: begin
            if (!run)           state_d = StIdle;
            else if (step_mode) state_d = StPause;
            else                state_d = StFetch;
         end
         StPause: begin
            if (!run)           state_d = StIdle;
            else if (step_edge) state_d = StFetch;
         end
         StHalt:   state_d = StHalt;
         default:  state_d = StIdle;
      endcase
   end

   // Strobes are registered alongside the state they decode; dec_w/dec_pcrel are stable
   // while the instruction register holds, so capturing them on WB entry is equivalent.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= StIdle;
         sw_sync_q   <= '0;
         step_sync_q <= '0;
         wait_cnt_q  <= '0;
         ir_load     <= 1'b0;
         pc_en       <= 1'b0;
         pc_branch   <= 1'b0;
         reg_we      <= 1'b0;
         halted      <= 1'b0;
         timeout     <= 1'b0;
         icount      <= '0;
      end else begin
         state_q     <= state_d;
         sw_sync_q   <= {sw_sync_q[1:0], sw_ready};
         step_sync_q <= {step_sync_q[1:0], step};
         ir_load     <= (state_d == StFetch);
         pc_en       <= (state_d == StWb);
         pc_branch   <= (state_d == StWb) & dec_pcrel;
         reg_we      <= (state_d == StWb) & dec_w;
         halted      <= (state_d == StHalt);

         if (state_q != StWaitSw) begin
            wait_cnt_q <= '0;
         end else if (!sw_edge && !wait_expired) begin
            wait_cnt_q <= wait_cnt_q + 32'd1;
         end

         // A handshake edge arriving on the expiry cycle wins: no timeout recorded.
         if (state_q == StWaitSw && !sw_edge && wait_expired) begin
            timeout <= 1'b1;
         end

         if (state_q == StWb && icount != '1) begin
            icount <= icount + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: cycle table, directed multi-cycle sequences and a random
// instruction stream checked against a timeline built from per-instruction rules.
module tb_cpu_sequencer;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic run = 1'b0, sw_ready = 1'b0, step_mode = 1'b0, step = 1'b0;
   logic dec_w = 1'b0, dec_pcrel = 1'b0, dec_wait = 1'b0, dec_halt = 1'b0;

   logic a_ir_load, a_pc_en, a_pc_branch, a_reg_we, a_halted, a_timeout;
   logic [2:0]  a_state;
   logic [15:0] a_icount;
   logic b_ir_load, b_pc_en, b_pc_branch, b_reg_we, b_halted, b_timeout;
   logic [2:0]  b_state;
   logic [3:0]  b_icount;

   cpu_sequencer #(.CW(16), .WAIT_MAX(0)) dut (
      .clk(clk), .reset(reset), .run(run), .sw_ready(sw_ready), .step_mode(step_mode),
      .step(step), .dec_w(dec_w), .dec_pcrel(dec_pcrel), .dec_wait(dec_wait),
      .dec_halt(dec_halt), .ir_load(a_ir_load), .pc_en(a_pc_en), .pc_branch(a_pc_branch),
      .reg_we(a_reg_we), .state(a_state), .halted(a_halted), .timeout(a_timeout),
      .icount(a_icount)
   );

   cpu_sequencer #(.CW(4), .WAIT_MAX(5)) dut_b (
      .clk(clk), .reset(reset), .run(run), .sw_ready(sw_ready), .step_mode(step_mode),
      .step(step), .dec_w(dec_w), .dec_pcrel(dec_pcrel), .dec_wait(dec_wait),
      .dec_halt(dec_halt), .ir_load(b_ir_load), .pc_en(b_pc_en), .pc_branch(b_pc_branch),
      .reg_we(b_reg_we), .state(b_state), .halted(b_halted), .timeout(b_timeout),
      .icount(b_icount)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int passed = 0;
   int irl_pulses = 0;
   int pce_pulses = 0;

   always @(negedge clk) begin
      if (a_ir_load) irl_pulses <= irl_pulses + 1;
      if (a_pc_en)   pce_pulses <= pce_pulses + 1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      repeat (n) tick();
   endtask

   task automatic do_reset();
      reset = 1'b0; run = 1'b0; sw_ready = 1'b0; step_mode = 1'b0; step = 1'b0;
      dec_w = 1'b0; dec_pcrel = 1'b0; dec_wait = 1'b0; dec_halt = 1'b0;
      ticks(3);
      reset = 1'b1;
   endtask

   // in = {run, step_mode, dec_w, dec_pcrel, dec_wait, dec_halt}
   // outs = {ir_load, pc_en, pc_branch, reg_we, halted}; expectations are after the edge
   typedef struct {
      logic [5:0] in;
      logic [2:0] st;
      logic [4:0] outs;
      int         ic;
   } vec_t;
   vec_t tbl[$];

   // Random-stream timeline, indexed by cycle number after reset release
   int st_of[512];
   int ins_of[512];
   int wb_of[32];
   int raise_of[32];
   bit rw[32], rp[32], rt[32];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n, bad, cyc, total, wbs, d, nw, i, t0, t1, t2, nirl, nwe, base;
      logic [3:0] exp_str;

      // Reset state
      do_reset();
      check("reset state", 32'(a_state), 32'd0);
      check("reset strobes", 32'({a_ir_load, a_pc_en, a_pc_branch, a_reg_we, a_halted}), 32'd0);
      check("reset timeout", 32'({a_timeout, b_timeout}), 32'd0);
      check("reset icount", 32'(a_icount), 32'd0);

      // Cycle table
      tbl.push_back('{6'b000000, 3'd0, 5'b00000, 0});
      tbl.push_back('{6'b100000, 3'd1, 5'b10000, 0});
      tbl.push_back('{6'b100000, 3'd2, 5'b00000, 0});
      tbl.push_back('{6'b001100, 3'd3, 5'b00000, 0});
      tbl.push_back('{6'b001100, 3'd5, 5'b01110, 0});
      tbl.push_back('{6'b001100, 3'd0, 5'b00000, 1});
      tbl.push_back('{6'b100000, 3'd1, 5'b10000, 1});
      tbl.push_back('{6'b100011, 3'd2, 5'b00000, 1});
      tbl.push_back('{6'b100100, 3'd3, 5'b00000, 1});
      tbl.push_back('{6'b100000, 3'd5, 5'b01000, 1});
      tbl.push_back('{6'b110000, 3'd6, 5'b00000, 2});
      tbl.push_back('{6'b110000, 3'd6, 5'b00000, 2});
      tbl.push_back('{6'b010000, 3'd0, 5'b00000, 2});
      tbl.push_back('{6'b100000, 3'd1, 5'b10000, 2});
      tbl.push_back('{6'b100000, 3'd2, 5'b00000, 2});
      tbl.push_back('{6'b100001, 3'd7, 5'b00001, 2});
      tbl.push_back('{6'b100000, 3'd7, 5'b00001, 2});
      foreach (tbl[k]) begin
         {run, step_mode, dec_w, dec_pcrel, dec_wait, dec_halt} = tbl[k].in;
         tick();
         check($sformatf("tbl[%0d] state", k), 32'(a_state), 32'(tbl[k].st));
         check($sformatf("tbl[%0d] strobes", k),
               32'({a_ir_load, a_pc_en, a_pc_branch, a_reg_we, a_halted}), 32'(tbl[k].outs));
         check($sformatf("tbl[%0d] icount", k), 32'(a_icount), 32'(tbl[k].ic));
      end

      // Reset mid-EXEC with a pending register write
      do_reset();
      run = 1'b1; dec_w = 1'b1;
      ticks(3);
      check("abort at exec", 32'(a_state), 32'd3);
      reset = 1'b0;
      #1;
      check("async reset state", 32'(a_state), 32'd0);
      nwe = 0;
      for (int k = 0; k < 2; k++) begin
         tick();
         if (a_reg_we) nwe++;
      end
      reset = 1'b1; run = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         if (a_reg_we) nwe++;
      end
      check("abort no reg_we", nwe, 0);
      check("abort icount", 32'(a_icount), 32'd0);
      check("abort idle", 32'(a_state), 32'd0);

      // Three plain instructions, then run=0 at the last WB
      do_reset();
      dec_w = 1'b1;
      nirl = 0; nwe = 0; t0 = 0; t1 = 0; t2 = 0;
      for (int s = 0; s < 13; s++) begin
         run = (s < 12);
         tick();
         if (a_ir_load) begin
            if (nirl == 0) t0 = s; else if (nirl == 1) t1 = s; else t2 = s;
            nirl++;
         end
         if (a_reg_we) nwe++;
      end
      check("plain ir_load count", nirl, 3);
      check("plain ir_load gap1", t1 - t0, 4);
      check("plain ir_load gap2", t2 - t1, 4);
      check("plain reg_we count", nwe, 3);
      check("plain icount", 32'(a_icount), 32'd3);
      check("plain idle after", 32'(a_state), 32'd0);

      // Level already high on WAITSW entry is not an edge
      do_reset();
      sw_ready = 1'b1;
      ticks(4);
      run = 1'b1; dec_wait = 1'b1; dec_w = 1'b1;
      ticks(4);
      check("wait entry", 32'(a_state), 32'd4);
      bad = 0;
      for (int k = 0; k < 10; k++) begin
         tick();
         if (a_state != 3'd4) bad++;
      end
      check("wait held on level", bad, 0);
      sw_ready = 1'b0;
      ticks(3);
      sw_ready = 1'b1;
      n = 0;
      while (a_state == 3'd4 && n < 10) begin
         tick();
         n++;
      end
      check("sw edge latency", n, 3);
      check("sw edge to wb", 32'(a_state), 32'd5);
      check("sw wb reg_we", 32'(a_reg_we), 32'd1);
      check("no timeout forever mode", 32'(a_timeout), 32'd0);

      // WAIT_MAX=5 expiry with no edge
      do_reset();
      run = 1'b1; dec_wait = 1'b1;
      ticks(4);
      check("tmo wait entry", 32'(b_state), 32'd4);
      n = 0;
      while (b_state == 3'd4 && n < 20) begin
         tick();
         n++;
      end
      check("tmo waitsw cycles", n, 5);
      check("tmo to wb", 32'(b_state), 32'd5);
      check("tmo set", 32'(b_timeout), 32'd1);
      dec_wait = 1'b0;
      ticks(8);
      check("tmo sticky", 32'(b_timeout), 32'd1);
      check("forever still waiting", 32'(a_state), 32'd4);
      check("forever no timeout", 32'(a_timeout), 32'd0);

      // Edge on the same cycle as expiry: edge wins
      do_reset();
      check("reset clears timeout", 32'(b_timeout), 32'd0);
      run = 1'b1; dec_wait = 1'b1;
      ticks(6);
      sw_ready = 1'b1;
      ticks(2);
      check("tie still waiting", 32'(b_state), 32'd4);
      tick();
      check("tie to wb", 32'(b_state), 32'd5);
      check("tie no timeout", 32'(b_timeout), 32'd0);
      check("tie strobes", 32'({b_ir_load, b_pc_en, b_pc_branch, b_reg_we, b_halted}),
            32'(5'b01000));

      // Single-step
      do_reset();
      run = 1'b1; step_mode = 1'b1; dec_w = 1'b1;
      ticks(5);
      check("step first pause", 32'(a_state), 32'd6);
      check("step first icount", 32'(a_icount), 32'd1);
      ticks(5);
      check("step pause holds", 32'(a_state), 32'd6);
      base = irl_pulses;
      step = 1'b1;
      n = 0;
      while (a_state == 3'd6 && n < 10) begin
         tick();
         n++;
      end
      check("step release latency", n, 3);
      ticks(12);
      check("step back in pause", 32'(a_state), 32'd6);
      check("step one fetch", irl_pulses - base, 1);
      check("step icount", 32'(a_icount), 32'd2);
      step = 1'b0;

      // Halt
      do_reset();
      run = 1'b1; dec_halt = 1'b1;
      ticks(3);
      check("halt state", 32'(a_state), 32'd7);
      check("halt flag", 32'(a_halted), 32'd1);
      dec_halt = 1'b0;
      base = pce_pulses;
      ticks(20);
      check("halt no pc_en", pce_pulses - base, 0);
      check("halt stays", 32'(a_state), 32'd7);
      check("halt icount", 32'(a_icount), 32'd0);

      // icount saturation (CW=4 instance) vs. 16-bit instance
      do_reset();
      run = 1'b1;
      ticks(69);
      check("icount 17 instrs", 32'(a_icount), 32'd17);
      check("icount saturates", 32'(b_icount), 32'd15);

      // Random instruction stream: every instruction is FETCH, DECODE, EXEC, optional
      // WAITSW run, WB; a handshake raised d slots after DECODE entry yields d+1 WAITSW cycles.
      do_reset();
      cyc = 1;
      for (int k = 0; k < 30; k++) begin
         rw[k] = 1'($urandom_range(0, 1));
         rp[k] = 1'($urandom_range(0, 1));
         rt[k] = ($urandom_range(0, 2) == 0);
         d = int'($urandom_range(0, 6));
         nw = rt[k] ? d + 1 : 0;
         raise_of[k] = cyc + 1 + d;
         wb_of[k] = cyc + 3 + nw;
         for (int j = 0; j <= 3 + nw; j++) begin
            ins_of[cyc + j] = k;
            st_of[cyc + j] = (j == 0) ? 1 : (j == 1) ? 2 : (j == 2) ? 3 : (j == 3 + nw) ? 5 : 4;
         end
         cyc = cyc + 4 + nw;
      end
      total = cyc;
      wbs = 0;
      for (int s = 0; s < total - 1; s++) begin
         run = 1'b1;
         if (s == 0) begin
            dec_w = 1'b0; dec_pcrel = 1'b0; dec_wait = 1'b0; sw_ready = 1'b0;
         end else begin
            i = ins_of[s];
            dec_w = rw[i]; dec_pcrel = rp[i]; dec_wait = rt[i];
            sw_ready = rt[i] && (s >= raise_of[i]) && (s < wb_of[i]);
         end
         tick();
         i = ins_of[s + 1];
         exp_str = {st_of[s + 1] == 1, st_of[s + 1] == 5,
                    (st_of[s + 1] == 5) && rp[i], (st_of[s + 1] == 5) && rw[i]};
         check($sformatf("rnd c%0d state", s + 1), 32'(a_state), 32'(st_of[s + 1]));
         check($sformatf("rnd c%0d strobes", s + 1),
               32'({a_ir_load, a_pc_en, a_pc_branch, a_reg_we}), 32'(exp_str));
         check($sformatf("rnd c%0d icount", s + 1), 32'(a_icount), 32'(wbs));
         if (st_of[s + 1] == 5) wbs++;
      end
      dec_w = 1'b0; dec_pcrel = 1'b0; dec_wait = 1'b0; sw_ready = 1'b0;
      tick();
      check("rnd final icount", 32'(a_icount), 32'd30);
      check("rnd no timeout", 32'(a_timeout), 32'd0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
